// File: rtl/pipelined_hca_adder.sv
// pipelined_hca_adder: Han-Carlson prefix adder with valid/ready pipeline; HCA_SIGNED_OVF_EN adds a signed-overflow output
module pipelined_hca_adder #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   S
`ifdef HCA_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int L = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] g, p, gg, pp, ng, np, fg, fp, c;
  logic [WIDTH:0] sum;
  logic [STAGES-1:0] v;
  logic [WIDTH:0] sr [STAGES];
  logic adv, xfer;
  always_comb begin
    g = X & Y;
    p = X ^ Y;
    gg = g;
    pp = p;
    ng = g;
    np = p;
    // Kogge-Stone over odd positions; distance 1 pulls in the raw even neighbour
    for (int l = 0; l < L; l++) begin
      ng = gg;
      np = pp;
      for (int i = 1; i < WIDTH; i += 2)
        if (i >= (1 << l)) begin
          ng[i] = gg[i] | (pp[i] & gg[i-(1<<l)]);
          np[i] = pp[i] & pp[i-(1<<l)];
        end
      gg = ng;
      pp = np;
    end
    fg = gg;
    fp = pp;
    for (int i = 2; i < WIDTH; i += 2) begin
      fg[i] = g[i] | (p[i] & gg[i-1]);
      fp[i] = p[i] & pp[i-1];
    end
    c = fg | (fp & {WIDTH{Cin}});
    sum = {c[WIDTH-1], p ^ {c[WIDTH-2:0], Cin}};
  end
  assign out_valid = v[STAGES-1];
  assign S = sr[STAGES-1];
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  assign xfer = in_valid & adv;
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) sr[i] <= '0;
    end else if (adv) begin
      v[0] <= in_valid;
      sr[0] <= xfer ? sum : sr[0];
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        sr[i] <= sr[i-1];
      end
    end
`ifdef HCA_SIGNED_OVF_EN
  logic [STAGES-1:0] ov;
  logic ovf_c;
  assign ovf_c = (X[WIDTH-1] & Y[WIDTH-1] & !sum[WIDTH-1]) | (!X[WIDTH-1] & !Y[WIDTH-1] & sum[WIDTH-1]);
  assign ovf = ov[STAGES-1];
  always_ff @(posedge clk)
    if (rst) ov <= '0;
    else if (adv) begin
      ov[0] <= xfer ? ovf_c : ov[0];
      for (int i = 1; i < STAGES; i++) ov[i] <= ov[i-1];
    end
`endif
endmodule

// File: tb/tb_pipelined_hca_adder.sv
// tb_pipelined_hca_adder: scoreboard bench for pipelined_hca_adder (WIDTH=9, STAGES=2)
module tb_pipelined_hca_adder;
  localparam int W = 9;
  localparam int ST = 2;
  logic clk = 0, rst = 0, in_valid = 0, in_ready, Cin = 0, out_valid, out_ready = 0;
  logic [W-1:0] X = '0, Y = '0;
  logic [W:0] S;
`ifdef HCA_SIGNED_OVF_EN
  logic ovf;
`endif
  logic [W:0] q [$];
  logic [W:0] e;
  int n_cmp = 0, n_err = 0;

  pipelined_hca_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready), .S(S)
`ifdef HCA_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [W:0] ref_sum(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    return (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
  endfunction

  task automatic test_reset();
    rst = 1; in_valid = 1; X = 5; Y = 5; out_ready = 0;
    tick(); tick();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (S !== '0) begin n_err++; $display("FAIL reset_S got %h want 0", S); end
    rst = 0; in_valid = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] xs [2] = '{9'd511, 9'h155};
    logic [W-1:0] ys [2] = '{9'd511, 9'h0AA};
    logic [W:0] es [2] = '{10'h3FF, 10'h200};
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; X = xs[k]; Y = ys[k]; Cin = 1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready[%0d] got %b want 1", k, in_ready); end
      tick();
      in_valid = 0; X = W'($urandom); Y = W'($urandom); Cin = 0;
      for (int j = 1; j < ST; j++) begin
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid[%0d] got %b want 0", k, out_valid); end
        tick();
      end
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d] got %b want 1", k, out_valid); end
      n_cmp++; if (S !== es[k]) begin n_err++; $display("FAIL basic_S[%0d] got %h want %h", k, S, es[k]); end
      tick();
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain[%0d] got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_stall();
    q.delete();
    out_ready = 0;
    in_valid = 1; X = 100; Y = 200; Cin = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_accept_a got %b want 1", in_ready); end
    q.push_back(ref_sum(X, Y, Cin));
    tick();
    X = 300; Y = 400; Cin = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_accept_b got %b want 1", in_ready); end
    q.push_back(ref_sum(X, Y, Cin));
    tick();
    for (int k = 0; k < 5; k++) begin
      X = W'($urandom); Y = W'($urandom);
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %b want 0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || S !== q[0]) begin n_err++; $display("FAIL stall_hold[%0d] got v=%b S=%h want v=1 S=%h", k, out_valid, S, q[0]); end
      tick();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      e = q.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || S !== e) begin n_err++; $display("FAIL stall_release[%0d] got v=%b S=%h want v=1 S=%h", k, out_valid, S, e); end
      tick();
    end
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0;
    q.delete();
    while ((sent < 100 || got < sent) && cyc < 2000) begin
      in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      X = W'($urandom); Y = W'($urandom); Cin = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++; if (S !== e) begin n_err++; $display("FAIL b2b_S[%0d] got %h want %h", got, S, e); end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sum(X, Y, Cin));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 0;
    n_cmp++; if (got != 100 || q.size() != 0) begin n_err++; $display("FAIL b2b_count got %0d left %0d want 100 left 0", got, q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    in_valid = 1; X = 3; Y = 4; Cin = 0;
    tick();
    rst = 1;
    tick();
    rst = 0; in_valid = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b0 || S === 10'd7) begin n_err++; $display("FAIL rstmid_flush[%0d] got v=%b S=%h want v=0", k, out_valid, S); end
      tick();
    end
    in_valid = 1; X = 1; Y = 2; Cin = 0;
    tick();
    in_valid = 0;
    for (int j = 1; j < ST; j++) tick();
    #1;
    n_cmp++; if (out_valid !== 1'b1 || S !== 10'd3) begin n_err++; $display("FAIL rstmid_recover got v=%b S=%h want v=1 S=003", out_valid, S); end
    tick();
  endtask

`ifdef HCA_SIGNED_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] xs [2] = '{9'h0FF, 9'h1FF};
    logic [W-1:0] ys [2] = '{9'h001, 9'h1FF};
    logic [W:0] es [2] = '{10'h100, 10'h3FE};
    logic os [2] = '{1'b1, 1'b0};
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; X = xs[k]; Y = ys[k]; Cin = 0;
      tick();
      in_valid = 0;
      for (int j = 1; j < ST; j++) tick();
      #1;
      n_cmp++; if (out_valid !== 1'b1 || S !== es[k]) begin n_err++; $display("FAIL ovf_S[%0d] got v=%b S=%h want S=%h", k, out_valid, S, es[k]); end
      n_cmp++; if (ovf !== os[k]) begin n_err++; $display("FAIL ovf_flag[%0d] got %b want %b", k, ovf, os[k]); end
      tick();
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef HCA_SIGNED_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_hca_adder.md
PIPELINED_HCA_ADDER -- requirements
Module: pipelined_hca_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 9, operand width in bits (legal 2..64).
REQ-002 SHALL have parameter STAGES, default 2, pipeline register stages from input to output (legal 1..4).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, operand set X/Y/Cin is valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port X, input, WIDTH, unsigned operand 1.
REQ-008 SHALL have port Y, input, WIDTH, unsigned operand 2.
REQ-009 SHALL have port Cin, input, 1, carry-in.
REQ-010 SHALL have port out_valid, output, 1, S holds a valid result.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts S this cycle.
REQ-012 SHALL have port S, output, WIDTH+1, sum; S[WIDTH] is carry-out.

Function
REQ-013 SHALL compute S = X + Y + Cin exactly, zero-extended to WIDTH+1 bits, never truncated.
REQ-014 SHALL build carries as a Han-Carlson prefix: bitwise G=X&Y, P=X^Y; Kogge-Stone prefix over odd bit positions in ceil(log2(WIDTH)) levels; one final level combining each even position with its odd neighbour below; Cin merged as G|(P&Cin) per position.
REQ-015 SHALL hold STAGES register stages, each with a valid bit; the registers are distributed across the G/P, prefix and sum levels, placement free.
REQ-016 SHALL use a global advance enable adv = !out_valid | out_ready; all stages shift only when adv=1.
REQ-017 SHALL drive in_ready = adv combinationally; a transfer occurs when in_valid & in_ready.
REQ-018 SHALL present an operand set accepted at cycle t on S with out_valid=1 at cycle t+STAGES when adv stays 1 throughout.
REQ-019 SHALL, when adv=1 and no transfer occurs, load a bubble (valid=0) into stage 1.
REQ-020 SHALL, when out_valid=1 and out_ready=0, hold S, out_valid and every stage's contents unchanged.
REQ-021 SHALL deliver results in acceptance order with no loss or duplication under any out_ready pattern.
REQ-022 SHALL ignore X/Y/Cin when the operand set is not transferred.

Reset
REQ-023 SHALL, while rst=1 at a rising edge, clear all stage valid bits, out_valid=0 and S=0.
REQ-024 SHALL drive in_ready=1 in the first cycle after rst is released.
REQ-025 SHALL, on rst mid-operation, discard all in-flight results; none appear after reset.
REQ-026 SHALL give rst priority over a simultaneous transfer in the same cycle.

Configuration
REQ-027 SHALL, with macro HCA_SIGNED_OVF_EN defined, add output ovf (1 bit), pipelined alongside S, equal to X[W-1]&Y[W-1]&!S[W-1] | !X[W-1]&!Y[W-1]&S[W-1] (W=WIDTH), reset to 0 and held under stall like S.
REQ-028 SHALL, without HCA_SIGNED_OVF_EN, have no ovf port and no associated logic; all other behaviour identical.

Verification
REQ-029 SHALL test WIDTH=9, STAGES=2: X=511, Y=511, Cin=1 accepted at t -> S=10'h3FF, out_valid=1 at t+2.
REQ-030 SHALL test X=0x155, Y=0x0AA, Cin=1 -> S=10'h200 (full carry ripple across all 9 bits).
REQ-031 SHALL test out_ready=0 for 5 cycles with 2 results in flight -> in_ready=0, S and out_valid frozen; on out_ready=1 results emerge in order on consecutive cycles.
REQ-032 SHALL test back-to-back 100 random transfers with random out_ready -> every S matches the reference sum, order preserved, count equal.
REQ-033 SHALL test rst=1 one cycle after accepting X=3, Y=4 -> out_valid=0 for all cycles after reset until a new transfer; value 7 never output.
REQ-034 SHALL test, with HCA_SIGNED_OVF_EN, X=0x0FF, Y=0x001, Cin=0 -> S=10'h100, ovf=1; X=0x1FF, Y=0x1FF -> ovf=0.
